stream_rr_arbiter: RTL



---
 rtl/stream_rr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin burst arbiter that merges N valid/ready byte
// streams onto one registered output stream tagged with the source channel.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitration bubble; picks the next requester after 'last'
// GRANT  | channel g owns the output until BL beats or a requester gap
module stream_rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = 2,
  parameter int DW = 8,
  parameter int BL = 16
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [N-1:0]    i_tready,
  input  logic [N-1:0]    i_tvalid,
  input  logic [N*DW-1:0] i_tdata,
  input  logic            o_tready,
  output logic            o_tvalid,
  output logic [DW-1:0]   o_tdata,
  output logic [CW-1:0]   o_tid
);

  localparam int BW = $clog2(BL + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   g;
  logic [CW-1:0]   last;
  logic [BW-1:0]   cnt;
  logic [BW-1:0]   cnt_inc;
  logic            load;
  logic            xfer;
  logic            gap;
  logic            req_any;
  logic            found;
  logic [CW-1:0]   nxt;
  logic [DW-1:0]   sel_data;

  // The output register can take a new beat when empty or being drained.
  assign load     = ~o_tvalid | o_tready;
  assign xfer     = (state == S_GRANT) & load & i_tvalid[g];
  assign gap      = (state == S_GRANT) & load & ~i_tvalid[g];
  assign cnt_inc  = cnt + BW'(1);
  assign req_any  = |i_tvalid;
  assign sel_data = i_tdata[int'(g)*DW +: DW];

  // Ready goes only to the granted channel and never looks at i_tvalid.
  always_comb begin
    i_tready = '0;
    if ((state == S_GRANT) && load) begin
      i_tready[g] = 1'b1;
    end
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    nxt   = last;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && i_tvalid[(int'(last) + i) % N]) begin
        nxt   = CW'((int'(last) + i) % N);
        found = 1'b1;
      end
    end
  end

  // Grant FSM: burst counter and last-served pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      g     <= '0;
      last  <= CW'(N - 1);
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            g     <= nxt;
            cnt   <= '0;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (xfer) begin
            cnt <= cnt_inc;
            if (cnt_inc == BW'(BL)) begin
              state <= S_IDLE;
              last  <= g;
            end
          end else if (gap) begin
            state <= S_IDLE;
            last  <= g;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single output register; data and id hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tid    <= '0;
    end else if (xfer) begin
      o_tvalid <= 1'b1;
      o_tdata  <= sel_data;
      o_tid    <= g;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule
